// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I sequencer: datapath control codes,
// opcodes, FSM state codes and trap causes.
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_TRAP = 3'd5
    } state_e;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    localparam logic [5:0] EXT_NONE        = 6'b000000;
    localparam logic [5:0] EXT_ITYPE_SHAMT = 6'b100000;
    localparam logic [5:0] EXT_ITYPE       = 6'b010000;
    localparam logic [5:0] EXT_STYPE       = 6'b001000;
    localparam logic [5:0] EXT_BTYPE       = 6'b000100;
    localparam logic [5:0] EXT_UTYPE       = 6'b000010;
    localparam logic [5:0] EXT_JTYPE       = 6'b000001;

    localparam logic [4:0] ALU_NOP  = 5'b00000;
    localparam logic [4:0] ALU_LUI  = 5'b00001;
    localparam logic [4:0] ALU_ADD  = 5'b00011;
    localparam logic [4:0] ALU_SUB  = 5'b00100;
    localparam logic [4:0] ALU_BNE  = 5'b00101;
    localparam logic [4:0] ALU_BLT  = 5'b00110;
    localparam logic [4:0] ALU_BGE  = 5'b00111;
    localparam logic [4:0] ALU_BLTU = 5'b01000;
    localparam logic [4:0] ALU_BGEU = 5'b01001;
    localparam logic [4:0] ALU_SLT  = 5'b01010;
    localparam logic [4:0] ALU_SLTU = 5'b01011;
    localparam logic [4:0] ALU_XOR  = 5'b01100;
    localparam logic [4:0] ALU_OR   = 5'b01101;
    localparam logic [4:0] ALU_AND  = 5'b01110;
    localparam logic [4:0] ALU_SLL  = 5'b01111;
    localparam logic [4:0] ALU_SRL  = 5'b10000;
    localparam logic [4:0] ALU_SRA  = 5'b10001;

    localparam logic [2:0] NPC_PLUS4  = 3'b000;
    localparam logic [2:0] NPC_BRANCH = 3'b001;
    localparam logic [2:0] NPC_JUMP   = 3'b010;
    localparam logic [2:0] NPC_JALR   = 3'b100;

    localparam logic [1:0] WD_FROM_ALU = 2'b00;
    localparam logic [1:0] WD_FROM_MEM = 2'b01;
    localparam logic [1:0] WD_FROM_PC  = 2'b10;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational instruction classifier: instruction class flags plus the
// immediate format, ALU operation and ALU B-source for the latched IR.
module mc_decode
    import mc_ctrl_pkg::*;
(
    input  logic [6:0] op_i,
    input  logic [6:0] funct7_i,
    input  logic [2:0] funct3_i,
    output logic       rtype_o,
    output logic       itype_r_o,
    output logic       load_o,
    output logic       store_o,
    output logic       branch_o,
    output logic       lui_o,
    output logic       jal_o,
    output logic       jalr_o,
    output logic       illegal_o,
    output logic [5:0] ext_op_o,
    output logic [4:0] alu_op_o,
    output logic       alu_src_o
);

    logic legal;
    logic f7_base;
    logic f7_alt;

    assign f7_base = (funct7_i == F7_BASE);
    assign f7_alt  = (funct7_i == F7_ALT);

    always_comb begin
        // NOTE: every output gets a default up front so no path through the case infers a latch.
        legal     = 1'b0;
        rtype_o   = 1'b0;
        itype_r_o = 1'b0;
        load_o    = 1'b0;
        store_o   = 1'b0;
        branch_o  = 1'b0;
        lui_o     = 1'b0;
        jal_o     = 1'b0;
        jalr_o    = 1'b0;
        ext_op_o  = EXT_NONE;
        alu_op_o  = ALU_NOP;
        alu_src_o = 1'b0;

        case (op_i)
            OP_RTYPE: begin
                rtype_o = 1'b1;
                legal   = f7_base || (f7_alt && (funct3_i == 3'b000 || funct3_i == 3'b101));
                case (funct3_i)
                    3'b000:  alu_op_o = f7_alt ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_op_o = ALU_SLL;
                    3'b010:  alu_op_o = ALU_SLT;
                    3'b011:  alu_op_o = ALU_SLTU;
                    3'b100:  alu_op_o = ALU_XOR;
                    3'b101:  alu_op_o = f7_alt ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_op_o = ALU_OR;
                    default: alu_op_o = ALU_AND;
                endcase
            end
            OP_ITYPE: begin
                itype_r_o = 1'b1;
                alu_src_o = 1'b1;
                ext_op_o  = EXT_ITYPE;
                legal     = 1'b1;
                case (funct3_i)
                    3'b000: alu_op_o = ALU_ADD;
                    3'b010: alu_op_o = ALU_SLT;
                    3'b011: alu_op_o = ALU_SLTU;
                    3'b100: alu_op_o = ALU_XOR;
                    3'b110: alu_op_o = ALU_OR;
                    3'b111: alu_op_o = ALU_AND;
                    3'b001: begin
                        alu_op_o = ALU_SLL;
                        ext_op_o = EXT_ITYPE_SHAMT;
                        legal    = f7_base;
                    end
                    default: begin
                        alu_op_o = f7_alt ? ALU_SRA : ALU_SRL;
                        ext_op_o = EXT_ITYPE_SHAMT;
                        legal    = f7_base || f7_alt;
                    end
                endcase
            end
            OP_LOAD: begin
                load_o    = 1'b1;
                alu_src_o = 1'b1;
                ext_op_o  = EXT_ITYPE;
                alu_op_o  = ALU_ADD;
                legal     = (funct3_i == 3'b010);
            end
            OP_STORE: begin
                store_o   = 1'b1;
                alu_src_o = 1'b1;
                ext_op_o  = EXT_STYPE;
                alu_op_o  = ALU_ADD;
                legal     = (funct3_i == 3'b010);
            end
            OP_BRANCH: begin
                branch_o = 1'b1;
                ext_op_o = EXT_BTYPE;
                legal    = 1'b1;
                case (funct3_i)
                    3'b000:  alu_op_o = ALU_SUB;
                    3'b001:  alu_op_o = ALU_BNE;
                    3'b100:  alu_op_o = ALU_BLT;
                    3'b101:  alu_op_o = ALU_BGE;
                    3'b110:  alu_op_o = ALU_BLTU;
                    3'b111:  alu_op_o = ALU_BGEU;
                    default: legal    = 1'b0;
                endcase
            end
            OP_LUI: begin
                lui_o     = 1'b1;
                alu_src_o = 1'b1;
                ext_op_o  = EXT_UTYPE;
                alu_op_o  = ALU_LUI;
                legal     = 1'b1;
            end
            OP_JAL: begin
                jal_o    = 1'b1;
                ext_op_o = EXT_JTYPE;
                legal    = 1'b1;
            end
            OP_JALR: begin
                jalr_o    = 1'b1;
                alu_src_o = 1'b1;
                ext_op_o  = EXT_ITYPE;
                alu_op_o  = ALU_ADD;
                legal     = (funct3_i == 3'b000);
            end
            default: legal = 1'b0;
        endcase

        illegal_o = ~legal;
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle RV32I sequencer: IF/ID/EX/MEM/WB FSM with a shared req/ack memory
// watchdog, sticky trap reporting and a retired-instruction counter.
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [6:0]  Op,
    input  logic [6:0]  Funct7,
    input  logic [2:0]  Funct3,
    input  logic        Zero,
    input  logic        imem_ack,
    input  logic        dmem_ack,
    output logic        imem_req,
    output logic        IRWrite,
    output logic        dmem_req,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        PCWrite,
    output logic        ALUSrc,
    output logic [5:0]  EXTOp,
    output logic [4:0]  ALUOp,
    output logic [2:0]  NPCOp,
    output logic [1:0]  WDSel,
    output logic        trap,
    output logic [1:0]  trap_cause,
    output logic [31:0] instret,
    output logic [2:0]  state
);

    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    state_e             state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [31:0]        instret_q, instret_d;
    logic               trap_q, trap_d;
    logic [1:0]         cause_q, cause_d;

    logic       rtype, itype_r, load, store, branch, lui, jal, jalr, illegal;
    logic [5:0] dec_ext;
    logic [4:0] dec_alu;
    logic       dec_alu_src;
    logic       timed_out;

    mc_decode u_decode (
        .op_i      (Op),
        .funct7_i  (Funct7),
        .funct3_i  (Funct3),
        .rtype_o   (rtype),
        .itype_r_o (itype_r),
        .load_o    (load),
        .store_o   (store),
        .branch_o  (branch),
        .lui_o     (lui),
        .jal_o     (jal),
        .jalr_o    (jalr),
        .illegal_o (illegal),
        .ext_op_o  (dec_ext),
        .alu_op_o  (dec_alu),
        .alu_src_o (dec_alu_src)
    );

    assign timed_out = (wait_q == WAIT_LAST);

    always_comb begin
        state_d   = state_q;
        wait_d    = '0;
        instret_d = instret_q;
        trap_d    = trap_q;
        cause_d   = cause_q;
        imem_req  = 1'b0;
        IRWrite   = 1'b0;
        dmem_req  = 1'b0;
        MemWrite  = 1'b0;
        RegWrite  = 1'b0;
        PCWrite   = 1'b0;
        ALUSrc    = 1'b0;
        EXTOp     = EXT_NONE;
        ALUOp     = ALU_NOP;
        NPCOp     = NPC_PLUS4;
        WDSel     = WD_FROM_ALU;

        if (state_q inside {S_EX, S_MEM, S_WB}) begin
            ALUSrc = dec_alu_src;
            EXTOp  = dec_ext;
            ALUOp  = dec_alu;
        end

        case (state_q)
            S_IF: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    IRWrite = 1'b1;
                    state_d = S_ID;
                end else if (timed_out) begin
                    state_d = S_TRAP;
                    trap_d  = 1'b1;
                    cause_d = CAUSE_TIMEOUT;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_ID: begin
                if (illegal) begin
                    state_d = S_TRAP;
                    trap_d  = 1'b1;
                    cause_d = CAUSE_ILLEGAL;
                end else begin
                    state_d = S_EX;
                end
            end
            S_EX: begin
                if (branch) begin
                    PCWrite = 1'b1;
                    NPCOp   = Zero ? NPC_BRANCH : NPC_PLUS4;
                    state_d = S_IF;
                end else if (load || store) begin
                    state_d = S_MEM;
                end else if (rtype || itype_r || lui || jal || jalr) begin
                    state_d = S_WB;
                end else begin
                    // Unreachable after a legal decode; kept so the FSM never stalls.
                    state_d = S_TRAP;
                    trap_d  = 1'b1;
                    cause_d = CAUSE_ILLEGAL;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                MemWrite = store;
                if (dmem_ack) begin
                    if (store) begin
                        PCWrite = 1'b1;
                        state_d = S_IF;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (timed_out) begin
                    state_d = S_TRAP;
                    trap_d  = 1'b1;
                    cause_d = CAUSE_TIMEOUT;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_WB: begin
                RegWrite = 1'b1;
                PCWrite  = 1'b1;
                WDSel    = load ? WD_FROM_MEM : ((jal || jalr) ? WD_FROM_PC : WD_FROM_ALU);
                NPCOp    = jal ? NPC_JUMP : (jalr ? NPC_JALR : NPC_PLUS4);
                state_d  = S_IF;
            end
            default: state_d = S_TRAP;
        endcase

        if (PCWrite) begin
            instret_d = instret_q + 32'd1;
        end

        // Requests drop in the same cycle reset is asserted, before the edge applies it.
        if (!rstn) begin
            imem_req = 1'b0;
            dmem_req = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rstn) begin
            state_q   <= S_IF;
            wait_q    <= '0;
            instret_q <= '0;
            trap_q    <= 1'b0;
            cause_q   <= CAUSE_NONE;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            instret_q <= instret_d;
            trap_q    <= trap_d;
            cause_q   <= cause_d;
        end
    end

    assign state      = state_q;
    assign instret    = instret_q;
    assign trap       = trap_q;
    assign trap_cause = cause_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: a per-cycle vector table for the normal instruction
// flows plus hand-written trap, watchdog and mid-transaction reset sequences.
module tb_mc_ctrl;

    localparam logic [6:0] R    = 7'h33;
    localparam logic [6:0] I    = 7'h13;
    localparam logic [6:0] LD   = 7'h03;
    localparam logic [6:0] ST   = 7'h23;
    localparam logic [6:0] BR   = 7'h63;
    localparam logic [6:0] JAL  = 7'h6F;
    localparam logic [6:0] JALR = 7'h67;

    logic        clk = 1'b0;
    logic        rstn;
    logic [6:0]  Op, Funct7;
    logic [2:0]  Funct3;
    logic        Zero, imem_ack, dmem_ack;
    logic        imem_req, IRWrite, dmem_req, MemWrite, RegWrite, PCWrite, ALUSrc;
    logic [5:0]  EXTOp;
    logic [4:0]  ALUOp;
    logic [2:0]  NPCOp;
    logic [1:0]  WDSel;
    logic        trap;
    logic [1:0]  trap_cause;
    logic [31:0] instret;
    logic [2:0]  state;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [2:0]  st;
        logic        ireq, irw, dreq, mw, rw, pcw, as;
        logic [1:0]  wd;
        logic [2:0]  npc;
        logic [4:0]  alu;
        logic [5:0]  ext;
        logic [31:0] ir;
    } out_t;

    typedef struct {
        logic       r;
        logic [6:0] op, f7;
        logic [2:0] f3;
        logic       z, ia, da;
        out_t       exp;
    } vec_t;

    vec_t tbl[$];

    mc_ctrl #(.TIMEOUT(4)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .Op         (Op),
        .Funct7     (Funct7),
        .Funct3     (Funct3),
        .Zero       (Zero),
        .imem_ack   (imem_ack),
        .dmem_ack   (dmem_ack),
        .imem_req   (imem_req),
        .IRWrite    (IRWrite),
        .dmem_req   (dmem_req),
        .MemWrite   (MemWrite),
        .RegWrite   (RegWrite),
        .PCWrite    (PCWrite),
        .ALUSrc     (ALUSrc),
        .EXTOp      (EXTOp),
        .ALUOp      (ALUOp),
        .NPCOp      (NPCOp),
        .WDSel      (WDSel),
        .trap       (trap),
        .trap_cause (trap_cause),
        .instret    (instret),
        .state      (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 ns later.
    task automatic drive(input logic r, input logic [6:0] op, input logic [6:0] f7,
                         input logic [2:0] f3, input logic z, input logic ia, input logic da);
        @(negedge clk);
        rstn = r; Op = op; Funct7 = f7; Funct3 = f3; Zero = z; imem_ack = ia; dmem_ack = da;
        #1;
    endtask

    function automatic out_t sample();
        out_t o;
        o = '{st: state, ireq: imem_req, irw: IRWrite, dreq: dmem_req, mw: MemWrite,
              rw: RegWrite, pcw: PCWrite, as: ALUSrc, wd: WDSel, npc: NPCOp,
              alu: ALUOp, ext: EXTOp, ir: instret};
        return o;
    endfunction

    function automatic logic [6:0] enables();
        return {imem_req, IRWrite, dmem_req, MemWrite, RegWrite, PCWrite, ALUSrc};
    endfunction

    task automatic v(input logic [6:0] op, input logic [6:0] f7, input logic [2:0] f3,
                     input logic z, input logic ia, input logic da,
                     input logic [2:0] st, input logic ireq, input logic irw, input logic dreq,
                     input logic mw, input logic rw, input logic pcw, input logic as,
                     input logic [1:0] wd, input logic [2:0] npc, input logic [4:0] alu,
                     input logic [5:0] ext, input logic [31:0] ir);
        vec_t t;
        t.r = 1'b1; t.op = op; t.f7 = f7; t.f3 = f3; t.z = z; t.ia = ia; t.da = da;
        t.exp = '{st: st, ireq: ireq, irw: irw, dreq: dreq, mw: mw, rw: rw, pcw: pcw,
                  as: as, wd: wd, npc: npc, alu: alu, ext: ext, ir: ir};
        tbl.push_back(t);
    endtask

    task automatic do_reset();
        drive(1'b0, R, 7'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic run_add();
        drive(1'b1, R, 7'h00, 3'd0, 1'b0, 1'b1, 1'b0);
        drive(1'b1, R, 7'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, R, 7'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, R, 7'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "bench time limit");
    end

    initial begin
        rstn = 1'b0; Op = '0; Funct7 = '0; Funct3 = '0; Zero = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;

        //  op    f7     f3   z  ia da   st ireq irw dreq mw rw pcw as  wd npc  alu     ext     ir
        // add x3,x1,x2: two fetch wait cycles, stray acks in ID/EX ignored
        v(R,    7'h00, 3'd0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 0, 0,  2'd0, 3'd0, 5'h00, 6'h00, 0);
        v(R,    7'h00, 3'd0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 0, 0,  2'd0, 3'd0, 5'h00, 6'h00, 0);
        v(R,    7'h00, 3'd0, 0, 1, 0,   0, 1, 1, 0, 0, 0, 0, 0,  2'd0, 3'd0, 5'h00, 6'h00, 0);
        v(R,    7'h00, 3'd0, 0, 1, 1,   1, 0, 0, 0, 0, 0, 0, 0,  2'd0, 3'd0, 5'h00, 6'h00, 0);
        v(R,    7'h00, 3'd0, 0, 0, 1,   2, 0, 0, 0, 0, 0, 0, 0,  2'd0, 3'd0, 5'h03, 6'h00, 0);
        v(R,    7'h00, 3'd0, 0, 0, 0,   4, 0, 0, 0, 0, 1, 1, 0,  2'd0, 3'd0, 5'h03, 6'h00, 0);
        // lw: fetch ack in the 4th cycle (watchdog boundary), dmem_ack after 3 waits
        v(LD,   7'h00, 3'd2, 0, 0, 0,   0, 1, 0, 0, 0, 0, 0, 0,  2'd0, 3'd0, 5'h00, 6'h00, 1);
        v(LD,   7'h00, 3'd2, 0, 0, 0,   0, 1, 0, 0, 0, 0, 0, 0,  2'd0, 3'd0, 5'h00, 6'h00, 1);
        v(LD,   7'h00, 3'd2, 0, 0, 0,   0, 1, 0, 0, 0, 0, 0, 0,  2'd0, 3'd0, 5'h00, 6'h00, 1);
        v(LD,   7'h00, 3'd2, 0, 1, 0,   0, 1, 1, 0, 0, 0, 0, 0,  2'd0, 3'd0, 5'h00, 6'h00, 1);
        v(LD,   7'h00, 3'd2, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0,  2'd0, 3'd0, 5'h00, 6'h00, 1);
        v(LD,   7'h00, 3'd2, 0, 0, 0,   2, 0, 0, 0, 0, 0, 0, 1,  2'd0, 3'd0, 5'h03, 6'h10, 1);
        v(LD,   7'h00, 3'd2, 0, 0, 0,   3, 0, 0, 1, 0, 0, 0, 1,  2'd0, 3'd0, 5'h03, 6'h10, 1);
        v(LD,   7'h00, 3'd2, 0, 0, 0,   3, 0, 0, 1, 0, 0, 0, 1,  2'd0, 3'd0, 5'h03, 6'h10, 1);
        v(LD,   7'h00, 3'd2, 0, 0, 0,   3, 0, 0, 1, 0, 0, 0, 1,  2'd0, 3'd0, 5'h03, 6'h10, 1);
        v(LD,   7'h00, 3'd2, 0, 0, 1,   3, 0, 0, 1, 0, 0, 0, 1,  2'd0, 3'd0, 5'h03, 6'h10, 1);
        v(LD,   7'h00, 3'd2, 0, 0, 0,   4, 0, 0, 0, 0, 1, 1, 1,  2'd1, 3'd0, 5'h03, 6'h10, 1);
        // beq taken, then bne not taken
        v(BR,   7'h00, 3'd0, 0, 1, 0,   0, 1, 1, 0, 0, 0, 0, 0,  2'd0, 3'd0, 5'h00, 6'h00, 2);
        v(BR,   7'h00, 3'd0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0,  2'd0, 3'd0, 5'h00, 6'h00, 2);
        v(BR,   7'h00, 3'd0, 1, 0, 0,   2, 0, 0, 0, 0, 0, 1, 0,  2'd0, 3'd1, 5'h04, 6'h04, 2);
        v(BR,   7'h00, 3'd1, 0, 1, 0,   0, 1, 1, 0, 0, 0, 0, 0,  2'd0, 3'd0, 5'h00, 6'h00, 3);
        v(BR,   7'h00, 3'd1, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0,  2'd0, 3'd0, 5'h00, 6'h00, 3);
        v(BR,   7'h00, 3'd1, 0, 0, 0,   2, 0, 0, 0, 0, 0, 1, 0,  2'd0, 3'd0, 5'h05, 6'h04, 3);
        // sw zero-wait
        v(ST,   7'h00, 3'd2, 0, 1, 0,   0, 1, 1, 0, 0, 0, 0, 0,  2'd0, 3'd0, 5'h00, 6'h00, 4);
        v(ST,   7'h00, 3'd2, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0,  2'd0, 3'd0, 5'h00, 6'h00, 4);
        v(ST,   7'h00, 3'd2, 0, 0, 0,   2, 0, 0, 0, 0, 0, 0, 1,  2'd0, 3'd0, 5'h03, 6'h08, 4);
        v(ST,   7'h00, 3'd2, 0, 0, 1,   3, 0, 0, 1, 1, 0, 1, 1,  2'd0, 3'd0, 5'h03, 6'h08, 4);
        // jal
        v(JAL,  7'h00, 3'd0, 0, 1, 0,   0, 1, 1, 0, 0, 0, 0, 0,  2'd0, 3'd0, 5'h00, 6'h00, 5);
        v(JAL,  7'h00, 3'd0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0,  2'd0, 3'd0, 5'h00, 6'h00, 5);
        v(JAL,  7'h00, 3'd0, 0, 0, 0,   2, 0, 0, 0, 0, 0, 0, 0,  2'd0, 3'd0, 5'h00, 6'h01, 5);
        v(JAL,  7'h00, 3'd0, 0, 0, 0,   4, 0, 0, 0, 0, 1, 1, 0,  2'd2, 3'd2, 5'h00, 6'h01, 5);
        // jalr
        v(JALR, 7'h00, 3'd0, 0, 1, 0,   0, 1, 1, 0, 0, 0, 0, 0,  2'd0, 3'd0, 5'h00, 6'h00, 6);
        v(JALR, 7'h00, 3'd0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0,  2'd0, 3'd0, 5'h00, 6'h00, 6);
        v(JALR, 7'h00, 3'd0, 0, 0, 0,   2, 0, 0, 0, 0, 0, 0, 1,  2'd0, 3'd0, 5'h03, 6'h10, 6);
        v(JALR, 7'h00, 3'd0, 0, 0, 0,   4, 0, 0, 0, 0, 1, 1, 1,  2'd2, 3'd4, 5'h03, 6'h10, 6);
        // srai
        v(I,    7'h20, 3'd5, 0, 1, 0,   0, 1, 1, 0, 0, 0, 0, 0,  2'd0, 3'd0, 5'h00, 6'h00, 7);
        v(I,    7'h20, 3'd5, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0,  2'd0, 3'd0, 5'h00, 6'h00, 7);
        v(I,    7'h20, 3'd5, 0, 0, 0,   2, 0, 0, 0, 0, 0, 0, 1,  2'd0, 3'd0, 5'h11, 6'h20, 7);
        v(I,    7'h20, 3'd5, 0, 0, 0,   4, 0, 0, 0, 0, 1, 1, 1,  2'd0, 3'd0, 5'h11, 6'h20, 7);

        // Reset state (requests forced low while rstn=0)
        @(posedge clk);
        do_reset();
        check("reset_state", {state, imem_req, dmem_req, trap, trap_cause, instret},
              {3'd0, 1'b0, 1'b0, 1'b0, 2'b00, 32'd0});

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].r, tbl[i].op, tbl[i].f7, tbl[i].f3, tbl[i].z, tbl[i].ia, tbl[i].da);
            check($sformatf("vec%0d", i), 64'(sample()), 64'(tbl[i].exp));
        end
        drive(1'b1, R, 7'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        check("after_table", {state, trap, instret}, {3'd0, 1'b0, 32'd8});

        // Fetch watchdog: no ack for 4 cycles
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, R, 7'h00, 3'd0, 1'b0, 1'b0, 1'b0);
            check($sformatf("tmo_if%0d", i), {state, trap, imem_req}, {3'd0, 1'b0, 1'b1});
        end
        drive(1'b1, R, 7'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        check("tmo_trap", {state, trap, trap_cause, imem_req}, {3'd5, 1'b1, 2'b10, 1'b0});
        do_reset();
        drive(1'b1, R, 7'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        check("trap_cleared", {state, trap, trap_cause}, {3'd0, 1'b0, 2'b00});

        // Illegal opcode after one retired add
        do_reset();
        run_add();
        drive(1'b1, 7'h7F, 7'h00, 3'd0, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 7'h7F, 7'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        check("ill_id", {state, trap}, {3'd1, 1'b0});
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 7'h7F, 7'h00, 3'd0, 1'b1, 1'b1, 1'b1);
            check($sformatf("ill_hold%0d", i), {state, trap, trap_cause, enables(), instret},
                  {3'd5, 1'b1, 2'b01, 7'd0, 32'd1});
        end

        // R-type with Funct7=0x01 (M extension) is not supported
        do_reset();
        drive(1'b1, R, 7'h01, 3'd0, 1'b0, 1'b1, 1'b0);
        drive(1'b1, R, 7'h01, 3'd0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, R, 7'h01, 3'd0, 1'b0, 1'b0, 1'b0);
        check("m_ext_trap", {state, trap, trap_cause, enables(), instret},
              {3'd5, 1'b1, 2'b01, 7'd0, 32'd0});

        // Reset while a load waits in S_MEM
        do_reset();
        run_add();
        drive(1'b1, LD, 7'h00, 3'd2, 1'b0, 1'b1, 1'b0);
        drive(1'b1, LD, 7'h00, 3'd2, 1'b0, 1'b0, 1'b0);
        drive(1'b1, LD, 7'h00, 3'd2, 1'b0, 1'b0, 1'b0);
        drive(1'b1, LD, 7'h00, 3'd2, 1'b0, 1'b0, 1'b0);
        check("mem_wait", {state, dmem_req, instret}, {3'd3, 1'b1, 32'd1});
        drive(1'b0, LD, 7'h00, 3'd2, 1'b0, 1'b0, 1'b0);
        check("mem_rst_drop", {state, dmem_req, imem_req}, {3'd3, 1'b0, 1'b0});
        drive(1'b1, R, 7'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        check("mem_rst_after", {state, instret, trap, imem_req, dmem_req},
              {3'd0, 32'd0, 1'b0, 1'b1, 1'b0});
        drive(1'b1, R, 7'h00, 3'd0, 1'b0, 1'b1, 1'b0);
        check("resume_fetch", {state, IRWrite}, {3'd0, 1'b1});
        drive(1'b1, R, 7'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        check("resume_id", {state, imem_req}, {3'd1, 1'b0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle sequencer for the RV32I datapath: steps each instruction through fetch, decode, execute, memory and write-back states. It drives the datapath with the same EXTOp/ALUOp/NPCOp/WDSel encodings as the single-cycle decoder. Instruction and data memory are shared, variable-latency slaves, accessed through a req/ack handshake with a watchdog. It sits between the instruction register/ALU datapath and the memory port, and also counts retired instructions.

## Interface
- TIMEOUT, 16: max cycles a memory request waits for ack before bus-timeout trap (≥1)
- clk  in  1  clock, rising edge
- rstn  in  1  synchronous reset, active-low
- Op  in  7  opcode from latched IR
- Funct7  in  7  funct7 from latched IR
- Funct3  in  3  funct3 from latched IR
- Zero  in  1  ALU branch-condition result, 1 = taken
- imem_ack  in  1  instruction word valid this cycle
- dmem_ack  in  1  data access complete this cycle
- imem_req  out  1  instruction fetch request
- IRWrite  out  1  load IR
- dmem_req  out  1  data access request
- MemWrite  out  1  data access is a store
- RegWrite  out  1  register file write
- PCWrite  out  1  update PC with NPC
- ALUSrc  out  1  ALU B from immediate
- EXTOp  out  6  immediate format, ctrl_encode_def.v values
- ALUOp  out  5  ALU operation, ctrl_encode_def.v values
- NPCOp  out  3  next-PC select
- WDSel  out  2  write-data select
- trap  out  1  sticky fault
- trap_cause  out  2  01 illegal instruction, 10 bus timeout, 00 none
- instret  out  32  retired-instruction count
- state  out  3  current state, debug

## Operation
- States: S_IF=0, S_ID=1, S_EX=2, S_MEM=3, S_WB=4, S_TRAP=5.
- S_IF
  - imem_req=1.
  - On imem_ack: IRWrite=1 for that cycle, go to S_ID.
- S_ID: classify from Op/Funct7/Funct3.
  - Supported: R-type (add, sub, and, or, xor, sll, srl, sra, slt, sltu), I-arith incl. shifts, lw, sw, beq/bne/blt/bge/bltu/bgeu, lui, jal, jalr.
  - Anything else: go to S_TRAP with cause 01.
  - Otherwise go to S_EX.
- S_EX: ALUOp, ALUSrc and EXTOp are driven per instruction. They stay stable through S_MEM/S_WB.
  - Branch: PCWrite=1, NPCOp=NPC_BRANCH if Zero else NPC_PLUS4; retire; go to S_IF.
  - lw/sw: go to S_MEM.
  - All others: go to S_WB.
- S_MEM: dmem_req=1; MemWrite=1 for sw.
  - On dmem_ack, sw: PCWrite=1, NPC_PLUS4, retire, go to S_IF.
  - On dmem_ack, lw: go to S_WB.
- S_WB: RegWrite=1 and PCWrite=1; retire; go to S_IF.
  - WDSel: FromMEM for lw, FromPC for jal/jalr, FromALU otherwise.
  - NPCOp: JUMP for jal, JALR for jalr, PLUS4 otherwise.
- S_TRAP
  - All enables and requests are 0.
  - Held until reset.
- Retire: PCWrite pulses exactly once per instruction. instret increments in the same cycle and wraps 0xFFFFFFFF→0.
- Watchdog
  - A wait counter clears on entry to S_IF/S_MEM and increments each cycle without ack.
  - If the counter equals TIMEOUT-1 and there is no ack: go to S_TRAP, cause 10.
  - Ack in that same cycle wins; no trap.
- rd=x0 writes are still issued; the register file discards them.

## Timing
- Outputs are combinational from the state register and the IR fields. No output is registered except instret, trap and trap_cause.
- Zero-wait memory latency (ack in the request cycle), in cycles per instruction:
  - branch: 3
  - R/I/lui/jal/jalr: 4
  - sw: 4
  - lw: 5
- Each wait cycle on ack adds one cycle.
- Reset: synchronous; applied at the rising edge with rstn=0.
  - Next state: S_IF, wait counter 0, instret 0, trap 0, trap_cause 00.
  - While rstn=0, imem_req and dmem_req are forced to 0.
- Reset mid-transaction drops the outstanding request; the memory slave must tolerate req deasserting.
- imem_ack outside S_IF and dmem_ack outside S_MEM are ignored.

## Structure
- Existing encodings stay in ctrl_encode_def.v: EXTOp, ALUOp, NPCOp, WDSel.
- New constants are added to the same include: state codes and trap cause codes.
- One sub-module, mc_decode (purely combinational), maps Op/Funct7/Funct3 to:
  - class flags: rtype, itype_r, load, store, branch, lui, jal, jalr, illegal;
  - EXTOp/ALUOp/ALUSrc.
- mc_ctrl holds the FSM, wait counter, instret and trap registers.

## Test plan
- add x3,x1,x2 with imem_ack in the request cycle:
  - states 0→1→2→4→0;
  - RegWrite and PCWrite high only in cycle 4;
  - WDSel=00; instret 0→1.
- lw with dmem_ack delayed 3 cycles:
  - S_MEM lasts 4 cycles, total 8 cycles;
  - WDSel=01 in S_WB; MemWrite=0 throughout.
- beq with Zero=1, then bne with Zero=0:
  - PCWrite in S_EX with NPCOp=001, then 000;
  - 3 cycles each; no RegWrite.
- Op=0x7F or Funct7=0x01 R-type:
  - trap=1, cause=01, state=5;
  - all enables 0 for 20 cycles; instret unchanged.
- TIMEOUT=4, imem_ack held low:
  - trap at the 4th S_IF cycle, cause=10.
  - Repeat with ack in the 4th cycle: no trap.
- rstn low for one edge while in S_MEM:
  - dmem_req drops immediately;
  - state=0, instret=0 next cycle;
  - normal fetch resumes after rstn goes high.
